// File: rtl/sram_axis_reader.sv
// Streams a contiguous SRAM word range from one bank onto an AXI4-Stream master.
// First beat two cycles after start; credit-limited reads keep at most two words buffered under backpressure.
module sram_axis_reader #(
  parameter int MAX_ADDR_WIDTH = 16,
  parameter int IDX_WIDTH      = 3,
  parameter int SRAM_WIDTH_O   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_WIDTH-1:0]      start_idx,
  input  logic [MAX_ADDR_WIDTH-1:0] start_addr,
  input  logic [MAX_ADDR_WIDTH:0]   start_len,
  output logic                      busy,
  output logic                      done,
  output logic                      sram_out_en,
  output logic [IDX_WIDTH-1:0]      sram_out_idx,
  output logic [MAX_ADDR_WIDTH-1:0] sram_out_addr,
  input  logic [SRAM_WIDTH_O-1:0]   sram_out_data,
  output logic [SRAM_WIDTH_O-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam int LW = MAX_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [MAX_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]             len_q, len_d;
  logic [LW-1:0]             rem_q, rem_d;
  logic [LW-1:0]             beat_q, beat_d;
  logic                      inflight_q;

  logic [SRAM_WIDTH_O-1:0]   buf_q [2];
  logic                      rd_ptr_q, wr_ptr_q;
  logic [1:0]                occ_q, occ_d;

  logic                      issue;
  logic                      pop;
  logic                      last_beat;
  logic                      store_push;
  logic                      store_pop;
  logic [SRAM_WIDTH_O-1:0]   head;

  // Credits come only from registered occupancy and in-flight state, so
  // the read strobe never depends combinationally on m_axis_tready.
  assign issue = (state_q == RUN) && (rem_q != '0) &&
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);

  assign sram_out_en   = issue;
  assign sram_out_idx  = idx_q;
  assign sram_out_addr = issue ? addr_q : '0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  // The returning word falls through to the stream when the buffer is empty;
  // if it is not taken that cycle it is stored and re-presented unchanged.
  assign m_axis_tvalid = (occ_q != 2'd0) || inflight_q;
  assign head          = (occ_q != 2'd0) ? buf_q[rd_ptr_q] : sram_out_data;
  assign m_axis_tdata  = m_axis_tvalid ? head : '0;
  assign last_beat     = (beat_q == (len_q - LW'(1)));
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign store_push    = inflight_q && !((occ_q == 2'd0) && pop);
  assign store_pop     = pop && (occ_q != 2'd0);
  assign occ_d         = occ_q + {1'b0, store_push} - {1'b0, store_pop};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    if (pop) begin
      beat_d = beat_q + LW'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = start_idx;
          addr_d  = start_addr;
          len_d   = start_len;
          rem_d   = start_len;
          beat_d  = '0;
          state_d = (start_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + MAX_ADDR_WIDTH'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      beat_q     <= beat_d;
      inflight_q <= issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (store_push) begin
        buf_q[wr_ptr_q] <= sram_out_data;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (store_pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(store_push && !store_pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_sram_axis_reader.sv
// Directed bench for sram_axis_reader with a behavioural one-cycle-latency SRAM.
module tb_sram_axis_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  start_idx;
  logic [15:0] start_addr;
  logic [16:0] start_len;
  logic        busy;
  logic        done;
  logic        sram_out_en;
  logic [2:0]  sram_out_idx;
  logic [15:0] sram_out_addr;
  logic [7:0]  sram_out_data = 8'h00;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int errors = 0;
  int checks = 0;

  logic [7:0]  bd[$];
  logic        bl[$];
  logic [15:0] ra[$];
  logic [2:0]  ri[$];
  int first_vld, done_cyc, done_cnt, busy_cnt, vld_cnt, unstable, addr_bad, max_out, en_cnt;

  sram_axis_reader #(
    .MAX_ADDR_WIDTH(16),
    .IDX_WIDTH(3),
    .SRAM_WIDTH_O(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_idx(start_idx),
    .start_addr(start_addr),
    .start_len(start_len),
    .busy(busy),
    .done(done),
    .sram_out_en(sram_out_en),
    .sram_out_idx(sram_out_idx),
    .sram_out_addr(sram_out_addr),
    .sram_out_data(sram_out_data),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  // Bank 2 holds addr+0x10; each further bank adds 0x20.
  function automatic logic [7:0] mem_word(input logic [2:0] idx, input logic [15:0] addr);
    return addr[7:0] + 8'h10 + {idx, 5'b00000} - 8'h40;
  endfunction

  always @(posedge clk) begin
    if (sram_out_en) sram_out_data <= mem_word(sram_out_idx, sram_out_addr);
  end

  task automatic do_start(input logic [2:0] idx, input logic [15:0] addr, input logic [16:0] len);
    start = 1'b1; start_idx = idx; start_addr = addr; start_len = len; m_axis_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observes cycles 1.. after the accepting edge; mode 1 drives tready 1,0,0 repeating.
  task automatic collect(input int mode, input int budget, input int inj_cyc);
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    int         outst;
    bd.delete(); bl.delete(); ra.delete(); ri.delete();
    first_vld = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; vld_cnt = 0;
    unstable = 0; addr_bad = 0; max_out = 0; en_cnt = 0;
    prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      m_axis_tready = (mode == 0) ? 1'b1 : ((c % 3) == 1);
      if (c == inj_cyc) begin
        start = 1'b1; start_idx = 3'd5; start_addr = 16'h0100; start_len = 17'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      outst = en_cnt - bd.size();
      if (outst > max_out) max_out = outst;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
        unstable++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (m_axis_tvalid) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = c;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        bd.push_back(m_axis_tdata);
        bl.push_back(m_axis_tlast);
      end
      if (sram_out_en) begin
        en_cnt++;
        ra.push_back(sram_out_addr);
        ri.push_back(sram_out_idx);
      end else if (sram_out_addr !== 16'h0000) begin
        addr_bad++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
      if (done_cyc > 0 && c >= done_cyc + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_idx = '0; start_addr = '0; start_len = '0; m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sram_out_en, m_axis_tvalid, m_axis_tlast} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000 (busy,done,en,tvalid,tlast)",
               {busy, done, sram_out_en, m_axis_tvalid, m_axis_tlast});
    end
    checks++;
    if ({sram_out_idx, sram_out_addr, m_axis_tdata} !== 27'h0) begin
      errors++;
      $display("FAIL reset_data: idx=%0h addr=%0h tdata=%0h expected all 0",
               sram_out_idx, sram_out_addr, m_axis_tdata);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, sram_out_en, m_axis_tvalid} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 000 (busy,en,tvalid)", {busy, sram_out_en, m_axis_tvalid});
    end
  endtask

  task automatic test_stream();
    do_start(3'd2, 16'h0000, 17'd8);
    collect(0, 40, -1);
    checks++;
    if (first_vld !== 2) begin errors++; $display("FAIL stream_first_valid: got cycle %0d expected 2", first_vld); end
    checks++;
    if (done_cyc !== 10) begin errors++; $display("FAIL stream_done_cycle: got %0d expected 10", done_cyc); end
    checks++;
    if (bd.size() !== 8 || vld_cnt !== 8) begin
      errors++; $display("FAIL stream_beats: got %0d beats %0d valid cycles expected 8 and 8", bd.size(), vld_cnt);
    end
    for (int k = 0; k < 8 && k < bd.size(); k++) begin
      checks++;
      if (bd[k] !== 8'(8'h10 + k) || bl[k] !== (k == 7)) begin
        errors++; $display("FAIL stream_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                           k, bd[k], bl[k], 8'(8'h10 + k), (k == 7));
      end
    end
    checks++;
    if (busy_cnt !== 10 || done_cnt !== 1) begin
      errors++; $display("FAIL stream_busy_done: got busy=%0d done=%0d expected 10 and 1", busy_cnt, done_cnt);
    end
    checks++;
    if (en_cnt !== 8 || addr_bad !== 0) begin
      errors++; $display("FAIL stream_reads: got %0d reads %0d stray addr expected 8 and 0", en_cnt, addr_bad);
    end
  endtask

  task automatic test_backpressure();
    do_start(3'd2, 16'h0000, 17'd8);
    collect(1, 100, -1);
    checks++;
    if (bd.size() !== 8) begin errors++; $display("FAIL bp_beats: got %0d expected 8", bd.size()); end
    for (int k = 0; k < 8 && k < bd.size(); k++) begin
      checks++;
      if (bd[k] !== 8'(8'h10 + k) || bl[k] !== (k == 7)) begin
        errors++; $display("FAIL bp_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                           k, bd[k], bl[k], 8'(8'h10 + k), (k == 7));
      end
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", unstable); end
    checks++;
    if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d expected at most 2", max_out); end
    checks++;
    if (done_cnt !== 1 || done_cyc < 0) begin
      errors++; $display("FAIL bp_done: got %0d pulses at cycle %0d expected 1 pulse", done_cnt, done_cyc);
    end
  endtask

  task automatic test_zero_len();
    do_start(3'd1, 16'h1234, 17'd0);
    collect(0, 10, -1);
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_cnt);
    end
    checks++;
    if (busy_cnt !== 1) begin errors++; $display("FAIL zero_busy: got %0d cycles expected 1", busy_cnt); end
    checks++;
    if (en_cnt !== 0 || vld_cnt !== 0 || addr_bad !== 0) begin
      errors++; $display("FAIL zero_activity: got reads=%0d valids=%0d stray=%0d expected 0 0 0",
                         en_cnt, vld_cnt, addr_bad);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4];
    logic [7:0]  exp_d [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_d = '{8'h0E, 8'h0F, 8'h10, 8'h11};
    do_start(3'd2, 16'hFFFE, 17'd4);
    collect(0, 30, -1);
    checks++;
    if (ra.size() !== 4 || bd.size() !== 4) begin
      errors++; $display("FAIL wrap_counts: got %0d reads %0d beats expected 4 and 4", ra.size(), bd.size());
    end
    for (int k = 0; k < 4 && k < ra.size() && k < bd.size(); k++) begin
      checks++;
      if (ra[k] !== exp_a[k] || bd[k] !== exp_d[k] || bl[k] !== (k == 3)) begin
        errors++; $display("FAIL wrap_word%0d: got addr=%0h data=%0h last=%0b expected addr=%0h data=%0h last=%0b",
                           k, ra[k], bd[k], bl[k], exp_a[k], exp_d[k], (k == 3));
      end
    end
    checks++;
    if (done_cyc !== 6) begin errors++; $display("FAIL wrap_done: got %0d expected 6", done_cyc); end
  endtask

  task automatic test_start_busy();
    int bad_idx;
    do_start(3'd2, 16'h0000, 17'd8);
    collect(0, 40, 4);
    bad_idx = 0;
    foreach (ri[k]) if (ri[k] !== 3'd2) bad_idx++;
    checks++;
    if (en_cnt !== 8 || bad_idx !== 0) begin
      errors++; $display("FAIL busy_reads: got %0d reads %0d foreign idx expected 8 and 0", en_cnt, bad_idx);
    end
    checks++;
    if (bd.size() !== 8) begin errors++; $display("FAIL busy_beats: got %0d expected 8", bd.size()); end
    for (int k = 0; k < 8 && k < bd.size(); k++) begin
      checks++;
      if (bd[k] !== 8'(8'h10 + k) || bl[k] !== (k == 7)) begin
        errors++; $display("FAIL busy_beat%0d: got data=%0h last=%0b expected data=%0h last=%0b",
                           k, bd[k], bl[k], 8'(8'h10 + k), (k == 7));
      end
    end
    checks++;
    if (done_cyc !== 10 || done_cnt !== 1) begin
      errors++; $display("FAIL busy_done: got cycle %0d count %0d expected 10 and 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    int stray;
    logic [7:0] exp_d [3];
    exp_d = '{8'h50, 8'h51, 8'h52};
    do_start(3'd2, 16'h0000, 17'd8);
    beats = 0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      m_axis_tready = 1'b1;
      #1;
      if (m_axis_tvalid && m_axis_tready) beats++;
      @(posedge clk); #1;
    end
    checks++;
    if (beats !== 3) begin errors++; $display("FAIL mid_pre_beats: got %0d expected 3", beats); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sram_out_en, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
        {sram_out_idx, sram_out_addr, m_axis_tdata} !== 27'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got ctrl=%b idx=%0h addr=%0h tdata=%0h expected all 0",
                         {busy, done, sram_out_en, m_axis_tvalid, m_axis_tlast},
                         sram_out_idx, sram_out_addr, m_axis_tdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (done || busy || m_axis_tvalid || sram_out_en) stray++;
      @(posedge clk); #1;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL mid_after_reset: got %0d active cycles expected 0", stray); end
    do_start(3'd3, 16'h0020, 17'd3);
    collect(0, 30, -1);
    checks++;
    if (bd.size() !== 3 || done_cyc !== 5) begin
      errors++; $display("FAIL mid_restart: got %0d beats done at %0d expected 3 and 5", bd.size(), done_cyc);
    end
    for (int k = 0; k < 3 && k < bd.size(); k++) begin
      checks++;
      if (bd[k] !== exp_d[k] || bl[k] !== (k == 2) || ri[k] !== 3'd3) begin
        errors++; $display("FAIL mid_beat%0d: got data=%0h last=%0b idx=%0d expected data=%0h last=%0b idx=3",
                           k, bd[k], bl[k], ri[k], exp_d[k], (k == 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
